vga_controller: RTL and testbench

VGA_CONTROLLER -- requirements
Module: vga_controller

---
 rtl/vga_controller.sv | 128 ++++++++++++
 tb/tb_vga_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_controller.sv
// VGA timing generator and game-screen renderer.
// Free-running pixel/line counters drive registered syncs and a colour
// pipeline. The score bar, border and game-over fill are decoded from
// per-frame snapshots of ingame/score, so one frame never mixes two states.
module vga_controller #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   // Screen geometry of the score bar and frame border.
   parameter int BAR_X0    = 64,
   parameter int BAR_UNIT  = 32,
   parameter int BAR_Y0    = 200,
   parameter int BAR_Y1    = 280,
   parameter int BORDER    = 4
) (
   input  logic        clk25,
   input  logic        reset,
   input  logic        ingame,
   input  logic [31:0] score,
   output logic        hSync,
   output logic        vSync,
   output logic [3:0]  VGA_R,
   output logic [3:0]  VGA_G,
   output logic [3:0]  VGA_B,
   inout  wire         ps2_clk,
   inout  wire         ps2_data
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  HS_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0]  HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0]  VS_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0]  H_ACT  = 10'(H_VISIBLE);
   localparam logic [9:0]  V_ACT  = 10'(V_VISIBLE);
   localparam logic [9:0]  BRD    = 10'(BORDER);
   localparam logic [9:0]  H_BRD  = 10'(H_VISIBLE - BORDER);
   localparam logic [9:0]  V_BRD  = 10'(V_VISIBLE - BORDER);
   localparam logic [9:0]  BY0    = 10'(BAR_Y0);
   localparam logic [9:0]  BY1    = 10'(BAR_Y1);
   localparam logic [15:0] BX0    = 16'(BAR_X0);
   localparam logic [15:0] BUNIT  = 16'(BAR_UNIT);

   // PS/2 pins are reserved: never driven, never read.
   assign ps2_clk  = 1'bz;
   assign ps2_data = 1'bz;

   logic [9:0]  h_count;
   logic [9:0]  v_count;
   logic        ingame_q;
   logic [31:0] score_q;

   logic [4:0]  bar_len;
   logic [15:0] bar_end;
   logic [15:0] x_ext;
   logic        active;
   logic        border;
   logic        in_bar;
   logic [11:0] rgb;

   // Pixel and line counters; the line counter advances on pixel wrap.
   always_ff @(posedge clk25 or negedge reset) begin
      if (!reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (h_count == H_LAST) begin
         h_count <= '0;
         v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
      end else begin
         h_count <= h_count + 10'd1;
      end
   end

   // Snapshot game state at the first pixel of each frame.
   always_ff @(posedge clk25 or negedge reset) begin
      if (!reset) begin
         ingame_q <= 1'b0;
         score_q  <= '0;
      end else if (h_count == '0 && v_count == '0) begin
         ingame_q <= ingame;
         score_q  <= score;
      end
   end

   // Colour decode for the current counter position.
   always_comb begin
      bar_len = (score_q >= 32'd16) ? 5'd16 : score_q[4:0];
      bar_end = BX0 + BUNIT * {11'd0, bar_len};
      x_ext   = {6'd0, h_count};
      active  = (h_count < H_ACT) && (v_count < V_ACT);
      border  = (h_count < BRD) || (h_count >= H_BRD) ||
                (v_count < BRD) || (v_count >= V_BRD);
      in_bar  = (x_ext >= BX0) && (x_ext < bar_end) &&
                (v_count >= BY0) && (v_count < BY1);
      rgb     = 12'h000;
      if (active) begin
         if (border)         rgb = 12'hFFF;
         else if (!ingame_q) rgb = 12'hF00;
         else if (in_bar)    rgb = 12'h0F0;
         else                rgb = 12'h004;
      end
   end

   // Output register: syncs and colour share one stage so they stay aligned.
   always_ff @(posedge clk25 or negedge reset) begin
      if (!reset) begin
         hSync <= 1'b1;
         vSync <= 1'b1;
         VGA_R <= 4'h0;
         VGA_G <= 4'h0;
         VGA_B <= 4'h0;
      end else begin
         hSync <= !((h_count >= HS_BEG) && (h_count < HS_END));
         vSync <= !((v_count >= VS_BEG) && (v_count < VS_END));
         {VGA_R, VGA_G, VGA_B} <= rgb;
      end
   end

endmodule

// File: tb/tb_vga_controller.sv
// Self-checking bench for vga_controller on a scaled-down screen so that
// several whole frames fit in a short run. Every cycle is compared against
// a position-from-elapsed-time model; a table of pixels pins exact colours.
module tb_vga_controller;

   localparam int HV = 64, HF = 4, HS = 8, HB = 4;
   localparam int VV = 32, VF = 2, VS = 2, VB = 4;
   localparam int BX0 = 8, BU = 3, BY0 = 16, BY1 = 24, BRD = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int NV = 22;

   logic        clk25 = 1'b0;
   logic        reset = 1'b0;
   logic        ingame = 1'b0;
   logic [31:0] score = '0;
   logic        hSync, vSync;
   logic [3:0]  VGA_R, VGA_G, VGA_B;
   wire         ps2_clk, ps2_data;

   int checks = 0;
   int failures = 0;
   bit done = 1'b0;

   // model state: cycles elapsed since reset release, and frame snapshot
   int          p = 0;
   int          last = 0;
   logic        m_ing = 1'b0;
   logic [31:0] m_sc = '0;

   typedef struct {
      logic        ing;
      logic [31:0] sc;
      int          x;
      int          y;
      logic [11:0] rgb;
   } vec_t;
   vec_t tbl[NV];

   int hf[$];
   int vf[$];

   always #5 clk25 = ~clk25;

   vga_controller #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .BAR_X0(BX0), .BAR_UNIT(BU), .BAR_Y0(BY0), .BAR_Y1(BY1), .BORDER(BRD)
   ) dut (
      .clk25(clk25), .reset(reset), .ingame(ingame), .score(score),
      .hSync(hSync), .vSync(vSync),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .ps2_clk(ps2_clk), .ps2_data(ps2_data)
   );

   function automatic logic [11:0] exp_rgb(int x, int y, logic ing, logic [31:0] sc);
      int bl;
      if (x >= HV || y >= VV) return 12'h000;
      if (x < BRD || x >= HV - BRD || y < BRD || y >= VV - BRD) return 12'hFFF;
      if (!ing) return 12'hF00;
      bl = (sc > 32'd16) ? 16 : int'(sc);
      if (y >= BY0 && y < BY1 && x >= BX0 && x < BX0 + BU * bl) return 12'h0F0;
      return 12'h004;
   endfunction

   function automatic logic [13:0] outs();
      return {hSync, vSync, VGA_R, VGA_G, VGA_B};
   endfunction

   task automatic summary();
      if (!done) begin
         done = 1'b1;
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
         if (failures >= 40) summary();
      end
   endtask

   task automatic timeout(string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out, got no event, required one", name);
   endtask

   // one clock; the snapshot is taken where the counters sit at frame start
   task automatic tick();
      int x, y;
      logic exp_h, exp_v;
      if (p % FT == 0) begin
         m_ing = ingame;
         m_sc  = score;
      end
      @(posedge clk25); #1;
      last = p;
      p++;
      x = last % HT;
      y = (last / HT) % VT;
      exp_h = !(x >= HV + HF && x < HV + HF + HS);
      exp_v = !(y >= VV + VF && y < VV + VF + VS);
      chk($sformatf("stream x=%0d y=%0d", x, y), 32'(outs()),
          32'({exp_h, exp_v, exp_rgb(x, y, m_ing, m_sc)}));
   endtask

   // advance until the current inputs have been snapshotted
   task automatic sync_frame();
      int n = 0;
      while (p % FT != 0 && n < FT) begin tick(); n++; end
      tick();
   endtask

   // advance until the outputs show pixel (x,y); always moves at least once
   task automatic run_to(int x, int y);
      int n = 0;
      int t = y * HT + x;
      do begin tick(); n++; end while (last % FT != t && n < 2 * FT);
      if (last % FT != t) timeout($sformatf("run_to %0d,%0d", x, y));
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic ph, pv;
      int hrun, vrun, hlow, vlow;

      // expected colours written out by hand from the screen rules
      tbl[0]  = '{1'b1, 32'd3,  1,  1,  12'hFFF};
      tbl[1]  = '{1'b1, 32'd3,  10, 15, 12'h004};
      tbl[2]  = '{1'b1, 32'd3,  7,  20, 12'h004};
      tbl[3]  = '{1'b1, 32'd3,  10, 20, 12'h0F0};
      tbl[4]  = '{1'b1, 32'd3,  16, 20, 12'h0F0};
      tbl[5]  = '{1'b1, 32'd3,  17, 20, 12'h004};
      tbl[6]  = '{1'b1, 32'd3,  10, 24, 12'h004};
      tbl[7]  = '{1'b1, 32'd40, 55, 20, 12'h0F0};
      tbl[8]  = '{1'b1, 32'd40, 56, 20, 12'h004};
      tbl[9]  = '{1'b1, 32'd40, 58, 20, 12'h004};
      tbl[10] = '{1'b1, 32'd15, 52, 20, 12'h0F0};
      tbl[11] = '{1'b1, 32'd15, 53, 20, 12'h004};
      tbl[12] = '{1'b1, 32'd0,  8,  20, 12'h004};
      tbl[13] = '{1'b1, 32'd0,  9,  20, 12'h004};
      tbl[14] = '{1'b1, 32'h8000_0003, 55, 20, 12'h0F0};
      tbl[15] = '{1'b1, 32'd16, 55, 20, 12'h0F0};
      tbl[16] = '{1'b1, 32'd16, 56, 20, 12'h004};
      tbl[17] = '{1'b0, 32'd5,  70, 10, 12'h000};
      tbl[18] = '{1'b0, 32'd5,  32, 20, 12'hF00};
      tbl[19] = '{1'b0, 32'd5,  63, 20, 12'hFFF};
      tbl[20] = '{1'b0, 32'd5,  10, 31, 12'hFFF};
      tbl[21] = '{1'b0, 32'd5,  20, 35, 12'h000};

      // reset held for 5 cycles: syncs idle high, colour black
      reset = 1'b0; ingame = 1'b1; score = 32'd3;
      repeat (5) begin
         @(posedge clk25); #1;
         chk("reset_out", 32'(outs()), 32'h3000);
      end

      // release; first hSync fall one register stage after the sync start
      reset = 1'b1; p = 0;
      n = 0;
      do begin tick(); n++; end while (hSync !== 1'b0 && n < 2 * HT);
      if (hSync !== 1'b0) timeout("first_hfall");
      else chk("first_hfall_cycles", n, HV + HF + 1);

      // two frames of sync timing
      ph = hSync; pv = vSync; hrun = 0; vrun = 0; hlow = -1; vlow = -1;
      repeat (2 * FT + HT) begin
         tick();
         if (ph && !hSync) hf.push_back(p);
         if (pv && !vSync) vf.push_back(p);
         if (!hSync) hrun++; else if (!ph) begin hlow = hrun; hrun = 0; end
         if (!vSync) vrun++; else if (!pv) begin vlow = vrun; vrun = 0; end
         ph = hSync; pv = vSync;
      end
      if (hf.size() < 2) timeout("h_period");
      else chk("h_period", hf[1] - hf[0], HT);
      chk("h_low", hlow, HS);
      if (vf.size() < 2) timeout("v_period");
      else chk("v_period", vf[1] - vf[0], FT);
      chk("v_low", vlow, VS * HT);

      // table of pixel colours
      for (int i = 0; i < NV; i++) begin
         if (i == 0 || tbl[i].ing != tbl[i-1].ing || tbl[i].sc != tbl[i-1].sc) begin
            ingame = tbl[i].ing;
            score  = tbl[i].sc;
            sync_frame();
         end
         run_to(tbl[i].x, tbl[i].y);
         chk($sformatf("vec%0d (%0d,%0d)", i, tbl[i].x, tbl[i].y),
             32'({VGA_R, VGA_G, VGA_B}), 32'(tbl[i].rgb));
      end

      // game state flips mid-frame: current frame keeps the old state
      ingame = 1'b1; score = 32'd5;
      sync_frame();
      run_to(10, 12);
      ingame = 1'b0; score = 32'd0;
      run_to(10, 20);
      chk("toggle_same_frame_bar", 32'({VGA_R, VGA_G, VGA_B}), 32'h0F0);
      run_to(32, 20);
      chk("toggle_same_frame_bg", 32'({VGA_R, VGA_G, VGA_B}), 32'h004);
      run_to(32, 20);
      chk("toggle_next_frame", 32'({VGA_R, VGA_G, VGA_B}), 32'hF00);

      // asynchronous reset in the middle of a red frame
      reset = 1'b0;
      #1;
      chk("async_reset", 32'(outs()), 32'h3000);
      repeat (2) begin
         @(posedge clk25); #1;
         chk("reset_hold", 32'(outs()), 32'h3000);
      end
      reset = 1'b1; p = 0;
      ingame = 1'b1; score = 32'd7;
      run_to(20, 20);
      chk("restart_pixel", 32'({VGA_R, VGA_G, VGA_B}), 32'h0F0);

      // random game state, changed at arbitrary cycles
      repeat (3 * FT) begin
         if ($urandom_range(0, 99) < 3) begin
            ingame = ($urandom_range(0, 3) != 0);
            score  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
         end
         tick();
      end

      summary();
   end

endmodule
